// File: rtl/fofb_pkg.sv
// fofb_pkg: shared status codes, tracker state encoding and popcount helper for the FOFB readout path
package fofb_pkg;

  localparam logic [1:0] ST_SUCCESS = 2'd0;
  localparam int POP_MAX = 256;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE, TIMEOUT} trackerState_t;

  // Bitmaps up to POP_MAX cells are zero-extended into the argument
  function automatic int unsigned popcount(input logic [POP_MAX-1:0] v);
    popcount = 0;
    for (int k = 0; k < POP_MAX; k++) popcount = popcount + 32'(v[k]);
  endfunction

endpackage

// File: rtl/fofb_us_tick.sv
// fofb_us_tick: 1us tick from SYSCLK_RATE; restart makes the first tick land half a period later
module fofb_us_tick #(
  parameter int SYSCLK_RATE = 100000000
) (
  input  logic sysClk,
  input  logic sysResetN,
  input  logic restart,
  output logic usTick
);

  localparam int FULL = (SYSCLK_RATE / 1000000 < 1) ? 1 : SYSCLK_RATE / 1000000;
  localparam int HALF = (SYSCLK_RATE / 2000000 < 1) ? 1 : SYSCLK_RATE / 2000000;
  localparam int W = $clog2(FULL + 1);

  logic [W-1:0] cnt;

  assign usTick = (cnt == '0) && !restart;

  // Down-counter reloads with a full period at each tick and with a half period on restart
  always_ff @(posedge sysClk or negedge sysResetN)
    if (!sysResetN) cnt <= '0;
    else if (restart) cnt <= W'(HALF - 1);
    else cnt <= (cnt == '0) ? W'(FULL - 1) : cnt - 1'b1;

endmodule

// File: rtl/fofb_cell_tracker.sv
// fofb_cell_tracker: per-FA-cycle cell arrival tracker; optional lateCount output under FOFB_CELL_TRACKER_LATE_COUNT_EN
module fofb_cell_tracker import fofb_pkg::*; #(
  parameter int SYSCLK_RATE      = 100000000,
  parameter int LINK_COUNT       = 2,
  parameter int MAX_CELLS        = 32,
  parameter int CELL_INDEX_WIDTH = $clog2(MAX_CELLS),
  parameter int CELL_COUNT_WIDTH = $clog2(MAX_CELLS + 1),
  parameter int TIMER_WIDTH      = 8,
  parameter int SEQNO_WIDTH      = 3
) (
  input  logic                                     sysClk,
  input  logic                                     sysResetN,
  input  logic                                     FAstrobe,
  input  logic [CELL_COUNT_WIDTH-1:0]              cfgCellCount,
  input  logic [TIMER_WIDTH-1:0]                   cfgTimeoutUs,
  input  logic [LINK_COUNT-1:0]                    cfgLinkEnable,
  input  logic [LINK_COUNT-1:0]                    statusValid,
  input  logic [2*LINK_COUNT-1:0]                  statusCode,
  input  logic [CELL_INDEX_WIDTH*LINK_COUNT-1:0]   statusCellIndex,
  input  logic [LINK_COUNT-1:0]                    statusFofbEnabled,
  output logic                                     readoutActive,
  output logic                                     readoutValid,
  output logic                                     readTimeoutStrobe,
  output logic                                     fofbEnabled,
  output logic [MAX_CELLS-1:0]                     rxBitmap,
  output logic [MAX_CELLS-1:0]                     fofbEnableBitmap,
  output logic [TIMER_WIDTH-1:0]                   readoutTime,
  output logic [SEQNO_WIDTH-1:0]                   seqno,
`ifdef FOFB_CELL_TRACKER_LATE_COUNT_EN
  output logic [15:0]                              lateCount,
`endif
  output logic [CELL_COUNT_WIDTH*LINK_COUNT-1:0]   linkPacketCount
);

  trackerState_t state;
  logic [CELL_COUNT_WIDTH-1:0] shadowCellCount, cellCounter, fofbCounter;
  logic [TIMER_WIDTH-1:0] shadowTimeoutUs, timer;
  logic [LINK_COUNT-1:0] shadowLinkEnable, accept;
  logic [MAX_CELLS-1:0] cellBitmap, fofbBitmap, orMask, orFofb, newMask, newFofb;
  logic [MAX_CELLS-1:0] linkMask [LINK_COUNT];
  logic [MAX_CELLS-1:0] linkFofb [LINK_COUNT];
  logic usTick, collecting;
`ifdef FOFB_CELL_TRACKER_LATE_COUNT_EN
  logic [LINK_COUNT-1:0] lateHit;
  logic [16:0] lateSum;
`endif

  fofb_us_tick #(.SYSCLK_RATE(SYSCLK_RATE)) uTick (
    .sysClk(sysClk),
    .sysResetN(sysResetN),
    .restart(FAstrobe),
    .usTick(usTick)
  );

  // A status coincident with FAstrobe belongs to the closed cycle and is dropped
  assign collecting = (state == ACTIVE) && !FAstrobe;

  for (genvar i = 0; i < LINK_COUNT; i++) begin : gLink
    logic [CELL_INDEX_WIDTH-1:0] idx;
    logic [CELL_COUNT_WIDTH-1:0] pktCount, pktPub;
    logic fmtOk;
    assign idx = statusCellIndex[i*CELL_INDEX_WIDTH +: CELL_INDEX_WIDTH];
    assign fmtOk = statusValid[i] && shadowLinkEnable[i] && (statusCode[2*i +: 2] == ST_SUCCESS) &&
                   (int'(idx) < MAX_CELLS);
    assign accept[i] = collecting && fmtOk;
    assign linkMask[i] = accept[i] ? (MAX_CELLS'(1) << idx) : '0;
    assign linkFofb[i] = statusFofbEnabled[i] ? linkMask[i] : '0;
    assign linkPacketCount[i*CELL_COUNT_WIDTH +: CELL_COUNT_WIDTH] = pktPub;
`ifdef FOFB_CELL_TRACKER_LATE_COUNT_EN
    assign lateHit[i] = ((state == DONE) || (state == TIMEOUT)) && !FAstrobe && fmtOk;
`endif
    // Saturating per-link success count, published and cleared at FAstrobe
    always_ff @(posedge sysClk or negedge sysResetN)
      if (!sysResetN) begin
        pktCount <= '0;
        pktPub <= '0;
      end else if (FAstrobe) begin
        pktPub <= pktCount;
        pktCount <= '0;
      end else if (accept[i] && (pktCount != '1)) pktCount <= pktCount + 1'b1;
  end

  // Merge all links' one-hot cells; duplicates within the cycle collapse here
  always_comb begin
    orMask = '0;
    orFofb = '0;
    for (int k = 0; k < LINK_COUNT; k++) begin
      orMask = orMask | linkMask[k];
      orFofb = orFofb | linkFofb[k];
    end
  end

  assign newMask = orMask & ~cellBitmap;
  assign newFofb = orFofb & ~fofbBitmap;

  // Readout FSM with working bitmaps, counters, timer and registered status outputs
  always_ff @(posedge sysClk or negedge sysResetN)
    if (!sysResetN) begin
      state <= IDLE;
      shadowCellCount <= '0;
      shadowTimeoutUs <= '0;
      shadowLinkEnable <= '0;
      cellBitmap <= '0;
      fofbBitmap <= '0;
      cellCounter <= '0;
      fofbCounter <= '0;
      timer <= '0;
      readoutActive <= 1'b0;
      readoutValid <= 1'b0;
      readTimeoutStrobe <= 1'b0;
      fofbEnabled <= 1'b0;
      rxBitmap <= '0;
      fofbEnableBitmap <= '0;
      readoutTime <= '0;
      seqno <= '0;
    end else begin
      readTimeoutStrobe <= 1'b0;
      if (FAstrobe) begin
        state <= ACTIVE;
        rxBitmap <= cellBitmap;
        fofbEnableBitmap <= fofbBitmap;
        cellBitmap <= '0;
        fofbBitmap <= '0;
        cellCounter <= '0;
        fofbCounter <= '0;
        timer <= '0;
        shadowCellCount <= cfgCellCount;
        shadowTimeoutUs <= (cfgTimeoutUs == '0) ? TIMER_WIDTH'(1) : cfgTimeoutUs;
        shadowLinkEnable <= cfgLinkEnable;
        readoutValid <= 1'b0;
        readoutActive <= 1'b1;
      end else if (state == ACTIVE) begin
        cellBitmap <= cellBitmap | newMask;
        fofbBitmap <= fofbBitmap | newFofb;
        cellCounter <= cellCounter + CELL_COUNT_WIDTH'(popcount(POP_MAX'(newMask)));
        fofbCounter <= fofbCounter + CELL_COUNT_WIDTH'(popcount(POP_MAX'(newFofb)));
        if (cellCounter == shadowCellCount) begin
          state <= DONE;
          readoutValid <= 1'b1;
          readoutActive <= 1'b0;
          fofbEnabled <= (fofbCounter == shadowCellCount);
          seqno <= seqno + 1'b1;
          readoutTime <= timer;
        end else if (timer == shadowTimeoutUs) begin
          state <= TIMEOUT;
          readTimeoutStrobe <= 1'b1;
          readoutActive <= 1'b0;
          fofbEnabled <= 1'b0;
          readoutTime <= timer;
        end else if (usTick) timer <= timer + 1'b1;
      end
    end

`ifdef FOFB_CELL_TRACKER_LATE_COUNT_EN
  assign lateSum = {1'b0, lateCount} + 17'(popcount(POP_MAX'(lateHit)));

  // Late or duplicate-link statuses after the cycle closed; cleared only by reset
  always_ff @(posedge sysClk or negedge sysResetN)
    if (!sysResetN) lateCount <= '0;
    else lateCount <= lateSum[16] ? 16'hFFFF : lateSum[15:0];
`endif

endmodule
